// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame scheduler for the VGA draw path.
// Each frame runs an erase pass over the enabled clients, a logic step,
// a position-increment step, then a colour draw pass. It owns the
// single plot port and muxes the active client's pixel stream onto it.
module draw_sequencer #(
    parameter int N          = 3,
    parameter int XW         = 10,
    parameter int YW         = 10,
    parameter int CW         = 3,
    parameter int TW         = 20,
    parameter int LOGIC_WAIT = 30,
    parameter int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            frame_tick,
    input  logic [N-1:0]    client_en,
    output logic [N-1:0]    client_go,
    input  logic [N-1:0]    client_done,
    input  logic [N*TW-1:0] client_timeout,
    input  logic [N*XW-1:0] client_x,
    input  logic [N*YW-1:0] client_y,
    input  logic [N*CW-1:0] client_colour,
    input  logic [N-1:0]    client_wr,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic [CW-1:0]   colour,
    output logic            writeEn,
    output logic            logic_go,
    output logic            inc_enable,
    output logic            erasing,
    output logic            busy,
    output logic [IW-1:0]   active,
    output logic [N-1:0]    timeout_err,
    output logic            overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_E_GO   = 3'd1,
        S_E_RUN  = 3'd2,
        S_LOGIC  = 3'd3,
        S_L_WAIT = 3'd4,
        S_INC    = 3'd5,
        S_D_GO   = 3'd6,
        S_D_RUN  = 3'd7
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_active;
    logic [TW-1:0]   r_cnt;
    logic [N-1:0]    r_mask;
    logic            r_pending;
    logic [N-1:0]    r_timeout_err;
    logic            r_overrun;

    logic [IW:0]     w_first_en;
    logic [IW:0]     w_first_mask;
    logic [IW:0]     w_next;
    logic            w_done;
    logic [TW-1:0]   w_tmo;
    logic [XW-1:0]   w_x;
    logic [YW-1:0]   w_y;
    logic [CW-1:0]   w_colour;
    logic            w_run;

    // Lowest set index of mask at or above start; MSB flags that one exists.
    function automatic logic [IW:0] find_from(input logic [N-1:0] mask, input int start);
        logic [IW:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((i >= start) && mask[i]) begin
                res = {1'b1, IW'(i)};
            end
        end
        return res;
    endfunction

    // Client selection and next-index search for the active client.
    always_comb begin
        w_first_en   = find_from(client_en, 0);
        w_first_mask = find_from(r_mask, 0);
        w_next       = find_from(r_mask, int'(r_active) + 1);
        w_done       = client_done[r_active];
        w_tmo        = client_timeout[r_active*TW +: TW];
        w_x          = client_x[r_active*XW +: XW];
        w_y          = client_y[r_active*YW +: YW];
        w_colour     = client_colour[r_active*CW +: CW];
        w_run        = (r_state == S_E_RUN) || (r_state == S_D_RUN);
    end

    // Output decode of registered state plus the pixel pass-through.
    always_comb begin
        busy        = (r_state != S_IDLE);
        erasing     = (r_state == S_E_GO) || (r_state == S_E_RUN);
        logic_go    = (r_state == S_LOGIC);
        inc_enable  = (r_state == S_INC);
        active      = r_active;
        timeout_err = r_timeout_err;
        overrun     = r_overrun;
        client_go   = '0;
        if ((r_state == S_E_GO) || (r_state == S_D_GO)) begin
            client_go[r_active] = 1'b1;
        end else begin
            client_go = '0;
        end
        x       = busy ? w_x : '0;
        y       = busy ? w_y : '0;
        colour  = (busy && !erasing) ? w_colour : '0;
        writeEn = w_run ? client_wr[r_active] : 1'b0;
    end

    // Frame FSM, RUN/wait counter, tick queue and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_active      <= '0;
            r_cnt         <= '0;
            r_mask        <= '0;
            r_pending     <= 1'b0;
            r_timeout_err <= '0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick || r_pending) begin
                        r_pending <= 1'b0;
                        r_mask    <= client_en;
                        r_cnt     <= '0;
                        r_active  <= w_first_en[IW-1:0];
                        r_state   <= w_first_en[IW] ? S_E_GO : S_LOGIC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_E_GO, S_D_GO: begin
                    r_cnt   <= '0;
                    r_state <= (r_state == S_E_GO) ? S_E_RUN : S_D_RUN;
                end
                S_E_RUN, S_D_RUN: begin
                    // done takes priority over a coincident timeout
                    if (w_done || (r_cnt == w_tmo)) begin
                        if (!w_done) begin
                            r_timeout_err[r_active] <= 1'b1;
                        end
                        if (w_next[IW]) begin
                            r_active <= w_next[IW-1:0];
                            r_state  <= (r_state == S_E_RUN) ? S_E_GO : S_D_GO;
                        end else begin
                            r_state <= (r_state == S_E_RUN) ? S_LOGIC : S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_LOGIC: begin
                    r_cnt   <= '0;
                    r_state <= S_L_WAIT;
                end
                S_L_WAIT: begin
                    if (r_cnt == TW'(LOGIC_WAIT - 1)) begin
                        r_state <= S_INC;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_INC: begin
                    r_active <= w_first_mask[IW-1:0];
                    r_state  <= w_first_mask[IW] ? S_D_GO : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // one-deep queue of ticks that arrive mid-frame
            if ((r_state != S_IDLE) && frame_tick) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Testbench for draw_sequencer: per-cycle comparison against a frame
// schedule computed from slot arithmetic, table-driven frame configs,
// hand sequences for tick queueing and mid-frame reset, and random frames.
module tb_draw_sequencer;
    localparam int N = 3, XW = 10, YW = 10, CW = 3, TW = 20, LW = 30, IW = 2;
    localparam int MAXC = 400;

    logic            clk, resetn, frame_tick;
    logic [N-1:0]    client_en, client_go, client_done, client_wr;
    logic [N*TW-1:0] client_timeout;
    logic [N*XW-1:0] client_x;
    logic [N*YW-1:0] client_y;
    logic [N*CW-1:0] client_colour;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            writeEn, logic_go, inc_enable, erasing, busy, overrun;
    logic [IW-1:0]   active;
    logic [N-1:0]    timeout_err;

    draw_sequencer #(.N(N), .XW(XW), .YW(YW), .CW(CW), .TW(TW), .LOGIC_WAIT(LW)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .client_en(client_en),
        .client_go(client_go), .client_done(client_done), .client_timeout(client_timeout),
        .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
        .client_wr(client_wr), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .logic_go(logic_go), .inc_enable(inc_enable), .erasing(erasing), .busy(busy),
        .active(active), .timeout_err(timeout_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests, n_fail, cyc;
    int go_cyc [N];
    int dly [N];
    int tmo [N];
    logic [XW-1:0] cx [N];
    logic [YW-1:0] cy [N];
    logic [CW-1:0] cc [N];
    logic          wr [N];

    logic [N-1:0] e_go [MAXC];
    bit e_lg [MAXC], e_inc [MAXC], e_busy [MAXC], e_er [MAXC], e_run [MAXC];
    int e_act [MAXC];

    typedef struct {
        logic [N-1:0]      en;
        logic [2:0][7:0]   d;
        logic [2:0][7:0]   t;
        logic [N-1:0]      err;
        int                len;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst_go", 32'(client_go), 32'd0);
        chk("rst_logic_go", 32'(logic_go), 32'd0);
        chk("rst_inc", 32'(inc_enable), 32'd0);
        chk("rst_erasing", 32'(erasing), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_writeEn", 32'(writeEn), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    // One clock: drive fresh client stimulus just after the edge, sample at negedge.
    task automatic step(input logic tk, input logic [N-1:0] en);
        @(posedge clk);
        #1;
        cyc++;
        frame_tick = tk;
        client_en  = en;
        for (int i = 0; i < N; i++) begin
            cx[i] = XW'($urandom);
            cy[i] = YW'($urandom);
            cc[i] = CW'($urandom);
            wr[i] = 1'($urandom);
            client_done[i] = (dly[i] != 0) && (go_cyc[i] >= 0) && (cyc == go_cyc[i] + dly[i]);
            client_x[i*XW +: XW]      = cx[i];
            client_y[i*YW +: YW]      = cy[i];
            client_colour[i*CW +: CW] = cc[i];
            client_timeout[i*TW +: TW] = TW'(tmo[i]);
            client_wr[i] = wr[i];
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (client_go[i]) go_cyc[i] = cyc;
        end
    endtask

    task automatic mark(input int k, input int a, input bit er, input bit run);
        e_busy[k] = 1'b1;
        e_act[k]  = a;
        e_er[k]   = er;
        e_run[k]  = run;
    endtask

    // Frame schedule: each enabled client takes 1 GO cycle plus min(done delay, T+1)
    // RUN cycles; erase pass from k=1, then logic, LW wait, inc, then draw pass.
    task automatic build(input logic [N-1:0] mask, output int endc, output logic [N-1:0] err);
        int c, r, last;
        for (int k = 0; k < MAXC; k++) begin
            e_go[k] = '0; e_lg[k] = 1'b0; e_inc[k] = 1'b0; e_busy[k] = 1'b0;
            e_er[k] = 1'b0; e_run[k] = 1'b0; e_act[k] = -1;
        end
        err = '0; c = 1; last = -1;
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                for (int j = 0; j < LW + 2; j++) mark(c + j, last, 1'b0, 1'b0);
                e_lg[c] = 1'b1;
                e_inc[c + 1 + LW] = 1'b1;
                c += LW + 2;
            end
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    if (dly[i] == 0 || dly[i] > tmo[i] + 1) begin
                        r = tmo[i] + 1;
                        err[i] = 1'b1;
                    end else begin
                        r = dly[i];
                    end
                    e_go[c][i] = 1'b1;
                    mark(c, i, p == 0, 1'b0);
                    for (int j = 1; j <= r; j++) mark(c + j, i, p == 0, 1'b1);
                    c += 1 + r;
                    last = i;
                end
            end
        end
        endc = c;
    endtask

    task automatic check_cycle(input int k);
        int a;
        a = e_act[k];
        chk("client_go", 32'(client_go), 32'(e_go[k]));
        chk("logic_go", 32'(logic_go), 32'(e_lg[k]));
        chk("inc_enable", 32'(inc_enable), 32'(e_inc[k]));
        chk("busy", 32'(busy), 32'(e_busy[k]));
        chk("erasing", 32'(erasing), 32'(e_er[k]));
        chk("writeEn", 32'(writeEn), 32'((e_run[k] && a >= 0) ? wr[a] : 1'b0));
        if (!e_busy[k]) begin
            chk("x_idle", 32'(x), 32'd0);
            chk("y_idle", 32'(y), 32'd0);
            chk("colour_idle", 32'(colour), 32'd0);
        end else if (a >= 0) begin
            chk("active", 32'(active), 32'(a));
            chk("x", 32'(x), 32'(cx[a]));
            chk("y", 32'(y), 32'(cy[a]));
            chk("colour", 32'(colour), 32'(e_er[k] ? {CW{1'b0}} : cc[a]));
        end
    endtask

    task automatic run_frame(input logic [N-1:0] mask, input bit pend, input bit rnd_en,
                             input int n_extra, output int bcnt, output logic [N-1:0] err);
        int endc;
        build(mask, endc, err);
        bcnt = 0;
        if (!pend) begin
            step(1'b1, mask);
            check_cycle(0);
        end
        for (int k = 1; k <= endc; k++) begin
            step((k >= 5) && (k < 5 + n_extra), rnd_en ? N'($urandom) : mask);
            check_cycle(k);
            if (busy) bcnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        frame_tick = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < N; i++) go_cyc[i] = -1;
    endtask

    initial begin
        int bc, endc;
        logic [N-1:0] err, acc;
        n_tests = 0; n_fail = 0; cyc = 0;
        resetn = 1'b0; frame_tick = 1'b0; client_en = '0; client_done = '0; client_wr = '0;
        client_timeout = '0; client_x = '0; client_y = '0; client_colour = '0;
        for (int i = 0; i < N; i++) begin
            go_cyc[i] = -1; dly[i] = 4; tmo[i] = 10;
            cx[i] = '0; cy[i] = '0; cc[i] = '0; wr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_rst();
        resetn = 1'b1;

        // en, done delays {c2,c1,c0} (0 = never), timeouts, expected err, frame length
        tbl[0] = '{3'b111, {8'd4, 8'd4, 8'd4},  {8'd10, 8'd10, 8'd10}, 3'b000, 63};
        tbl[1] = '{3'b101, {8'd4, 8'd4, 8'd4},  {8'd10, 8'd10, 8'd10}, 3'b000, 53};
        tbl[2] = '{3'b111, {8'd4, 8'd0, 8'd4},  {8'd10, 8'd10, 8'd10}, 3'b010, 77};
        tbl[3] = '{3'b000, {8'd4, 8'd4, 8'd4},  {8'd10, 8'd10, 8'd10}, 3'b000, 33};
        tbl[4] = '{3'b111, {8'd4, 8'd11, 8'd4}, {8'd10, 8'd10, 8'd10}, 3'b000, 77};
        tbl[5] = '{3'b010, {8'd0, 8'd3, 8'd0},  {8'd5, 8'd1, 8'd5},    3'b010, 39};
        tbl[6] = '{3'b100, {8'd1, 8'd0, 8'd0},  {8'd5, 8'd5, 8'd5},    3'b000, 37};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                dly[i] = int'(tbl[v].d[i]);
                tmo[i] = int'(tbl[v].t[i]);
            end
            run_frame(tbl[v].en, 1'b0, 1'b0, 0, bc, err);
            chk("tbl_busy_cycles", 32'(bc), 32'(tbl[v].len - 1));
            chk("tbl_timeout_err", 32'(timeout_err), 32'(tbl[v].err));
        end

        // three ticks while busy: one queued frame, overrun sticky, no third frame
        do_reset();
        for (int i = 0; i < N; i++) begin dly[i] = 4; tmo[i] = 10; end
        chk("overrun_clear", 32'(overrun), 32'd0);
        run_frame(3'b111, 1'b0, 1'b0, 3, bc, err);
        chk("overrun_set", 32'(overrun), 32'd1);
        run_frame(3'b111, 1'b1, 1'b0, 0, bc, err);
        chk("pending_frame_busy", 32'(bc), 32'd62);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'b111);
            chk("no_third_frame", 32'(busy), 32'd0);
        end

        // reset pulled during the last draw client's RUN
        do_reset();
        build(3'b111, endc, err);
        step(1'b1, 3'b111);
        check_cycle(0);
        for (int k = 1; k <= endc - 3; k++) begin
            step(1'b0, 3'b111);
            check_cycle(k);
        end
        #1 resetn = 1'b0;
        #1 chk_rst();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 3'b111);
            chk("rst_hold_go", 32'(client_go), 32'd0);
            chk("rst_hold_busy", 32'(busy), 32'd0);
        end
        resetn = 1'b1;
        for (int i = 0; i < N; i++) go_cyc[i] = -1;
        run_frame(3'b111, 1'b0, 1'b0, 0, bc, err);
        chk("post_rst_busy", 32'(bc), 32'd62);

        // random frames, client_en scrambled mid-frame, sticky errors accumulate
        do_reset();
        acc = '0;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < N; i++) begin
                dly[i] = int'($urandom_range(0, 14));
                tmo[i] = int'($urandom_range(1, 12));
            end
            run_frame(N'($urandom), 1'b0, 1'b1, 0, bc, err);
            acc = acc | err;
            chk("rnd_timeout_err", 32'(timeout_err), 32'(acc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
